avst_mult_stream: RTL and testbench

AVST_MULT_STREAM -- requirements
Module: avst_mult_stream

---
 rtl/avst_mult_stream.sv | 199 +++++++++++++++++++
 tb/tb_avst_mult_stream.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avst_mult_stream.sv
`default_nettype none
// ============================================================================
// Module : avst_mult_stream
// Byte-serial Avalon-ST multiplier: receives A/B operand packets and streams
// out the 2*SZ-bit product. Define AVST_MULT_ERR_EN to add err_out/err_cnt.
// Rev    : 1.0  initial release
// ============================================================================
module avst_mult_stream #(
  parameter int SZ = 32
) (
  input  logic       clk,
  input  logic       _rst,
  input  logic       valid_in,
  output logic       ready_out,
  input  logic       startofpacket_in,
  input  logic       endofpacket_in,
  input  logic [7:0] data_in,
  output logic       valid_out,
  input  logic       ready_in,
  output logic       startofpacket_out,
  output logic       endofpacket_out,
  output logic [7:0] data_out
`ifdef AVST_MULT_ERR_EN
  ,
  output logic       err_out,
  output logic [7:0] err_cnt
`endif
);

  localparam int c_BEATS  = SZ / 8;
  localparam int c_OBEATS = 2 * c_BEATS;
  localparam int c_IW     = $clog2(c_OBEATS);
  localparam logic [c_IW-1:0] c_RX_LAST = c_IW'(c_BEATS - 1);
  localparam logic [c_IW-1:0] c_TX_LAST = c_IW'(c_OBEATS - 1);

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_PAYLOAD = 2'd1,
    RX_DISCARD = 2'd2
  } rx_state_t;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

  rx_state_t        r_rx_state;
  logic [c_IW-1:0]  r_rx_idx;
  logic [SZ-1:0]    r_shadow;
  logic             r_tgt_b;
  logic [SZ-1:0]    r_a;
  logic [SZ-1:0]    r_b;
  logic             r_pend_a;
  logic             r_pend_b;
  logic [2*SZ-1:0]  r_result;
  tx_state_t        r_tx_state;
  logic [c_IW-1:0]  r_tx_idx;

  logic             w_accept;
  logic             w_hdr_ok;
  logic             w_rx_last;
  logic [SZ-1:0]    w_shadow_nxt;
  logic             w_commit_a;
  logic             w_commit_b;
  logic             w_launch;
  logic [2*SZ-1:0]  w_a_ext;
  logic [2*SZ-1:0]  w_b_ext;
  logic [2*SZ-1:0]  w_product;
  logic [c_IW-1:0]  w_tx_idx_nxt;
  logic [2*SZ-1:0]  w_tx_shift;

  assign ready_out    = !(r_pend_a && r_pend_b);
  assign w_accept     = valid_in && ready_out;
  assign w_hdr_ok     = (data_in == 8'h01) || (data_in == 8'h02);
  assign w_rx_last    = (r_rx_idx == c_RX_LAST);
  assign w_shadow_nxt = SZ'({r_shadow, data_in});

  // Commit only on an in-sequence eop landing exactly on the last payload byte.
  assign w_commit_a = w_accept && (r_rx_state == RX_PAYLOAD) && !startofpacket_in &&
                      endofpacket_in && w_rx_last && !r_tgt_b;
  assign w_commit_b = w_accept && (r_rx_state == RX_PAYLOAD) && !startofpacket_in &&
                      endofpacket_in && w_rx_last && r_tgt_b;

  assign w_launch     = r_pend_a && r_pend_b && (r_tx_state == TX_IDLE);
  assign w_a_ext      = {{SZ{1'b0}}, r_a};
  assign w_b_ext      = {{SZ{1'b0}}, r_b};
  assign w_product    = w_a_ext * w_b_ext;
  assign w_tx_idx_nxt = r_tx_idx + 1'b1;
  assign w_tx_shift   = r_result << {w_tx_idx_nxt, 3'b000};

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_idx   <= '0;
      r_shadow   <= '0;
      r_tgt_b    <= 1'b0;
    end else if (w_accept) begin
      if ((r_rx_state != RX_DISCARD) && startofpacket_in) begin
        // Any sop outside DISCARD is treated as a fresh header.
        r_rx_idx <= '0;
        r_tgt_b  <= data_in[1];
        if (w_hdr_ok)
          r_rx_state <= RX_PAYLOAD;
        else
          r_rx_state <= endofpacket_in ? RX_IDLE : RX_DISCARD;
      end else begin
        case (r_rx_state)
          RX_PAYLOAD: begin
            r_shadow <= w_shadow_nxt;
            r_rx_idx <= r_rx_idx + 1'b1;
            if (endofpacket_in)
              r_rx_state <= RX_IDLE;
            else if (w_rx_last)
              r_rx_state <= RX_DISCARD;
          end
          RX_DISCARD: begin
            if (endofpacket_in)
              r_rx_state <= RX_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_pend_a <= 1'b0;
      r_pend_b <= 1'b0;
    end else begin
      if (w_commit_a)
        r_a <= w_shadow_nxt;
      if (w_commit_b)
        r_b <= w_shadow_nxt;
      r_pend_a <= (r_pend_a && !w_launch) || w_commit_a;
      r_pend_b <= (r_pend_b && !w_launch) || w_commit_b;
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_tx_state        <= TX_IDLE;
      r_tx_idx          <= '0;
      r_result          <= '0;
      valid_out         <= 1'b0;
      startofpacket_out <= 1'b0;
      endofpacket_out   <= 1'b0;
      data_out          <= 8'h00;
    end else if (r_tx_state == TX_IDLE) begin
      if (w_launch) begin
        r_tx_state        <= TX_SEND;
        r_tx_idx          <= '0;
        r_result          <= w_product;
        valid_out         <= 1'b1;
        startofpacket_out <= 1'b1;
        endofpacket_out   <= 1'b0;
        data_out          <= w_product[2*SZ-1 -: 8];
      end
    end else if (ready_in) begin
      if (r_tx_idx == c_TX_LAST) begin
        r_tx_state        <= TX_IDLE;
        r_tx_idx          <= '0;
        valid_out         <= 1'b0;
        startofpacket_out <= 1'b0;
        endofpacket_out   <= 1'b0;
        data_out          <= 8'h00;
      end else begin
        r_tx_idx          <= w_tx_idx_nxt;
        startofpacket_out <= 1'b0;
        endofpacket_out   <= (w_tx_idx_nxt == c_TX_LAST);
        data_out          <= w_tx_shift[2*SZ-1 -: 8];
      end
    end
  end

`ifdef AVST_MULT_ERR_EN
  logic w_malformed;

  // One event per offending beat, even when a restart header is also invalid.
  assign w_malformed = w_accept && (
      ((r_rx_state == RX_IDLE) && (!startofpacket_in || !w_hdr_ok)) ||
      ((r_rx_state == RX_PAYLOAD) && (startofpacket_in || (endofpacket_in != w_rx_last))));

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      err_out <= 1'b0;
      err_cnt <= 8'h00;
    end else begin
      err_out <= w_malformed;
      if (w_malformed && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'h01;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_avst_mult_stream.sv
`default_nettype none
// ============================================================================
// Module : tb_avst_mult_stream
// Randomized bench for avst_mult_stream against a packet/queue level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_avst_mult_stream;

  localparam int SZ    = 32;
  localparam int BEATS = SZ / 8;
  localparam int OB    = 2 * BEATS;

  logic       clk = 1'b0;
  logic       _rst;
  logic       valid_in;
  logic       ready_out;
  logic       startofpacket_in;
  logic       endofpacket_in;
  logic [7:0] data_in;
  logic       valid_out;
  logic       ready_in;
  logic       startofpacket_out;
  logic       endofpacket_out;
  logic [7:0] data_out;
`ifdef AVST_MULT_ERR_EN
  logic       err_out;
  logic [7:0] err_cnt;
`endif

  avst_mult_stream #(.SZ(SZ)) u_dut (
    .clk               (clk),
    ._rst              (_rst),
    .valid_in          (valid_in),
    .ready_out         (ready_out),
    .startofpacket_in  (startofpacket_in),
    .endofpacket_in    (endofpacket_in),
    .data_in           (data_in),
    .valid_out         (valid_out),
    .ready_in          (ready_in),
    .startofpacket_out (startofpacket_out),
    .endofpacket_out   (endofpacket_out),
    .data_out          (data_out)
`ifdef AVST_MULT_ERR_EN
    ,
    .err_out           (err_out),
    .err_cnt           (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] d;
  } beat_t;

  beat_t        inq[$];
  logic [7:0]   cur[$];
  logic [7:0]   txq[$];
  bit           mdisc;
  logic [SZ-1:0] ma, mb;
  bit           mpa, mpb;
  bit           merr;
  int           mcnt;
  int           rmode;
  int           vpct;
  bit           ph;

  task automatic model_reset();
    inq.delete(); cur.delete(); txq.delete();
    mdisc = 0; ma = '0; mb = '0; mpa = 0; mpb = 0; merr = 0; mcnt = 0;
  endtask

  task automatic put(input bit s, input bit e, input logic [7:0] d);
    beat_t b;
    b.sop = s; b.eop = e; b.d = d;
    inq.push_back(b);
  endtask

  task automatic pkt_good(input logic [7:0] h, input logic [SZ-1:0] v);
    put(1, 0, h);
    for (int i = BEATS - 1; i >= 0; i--) put(0, i == 0, v[i*8 +: 8]);
  endtask

  task automatic pkt_short(input logic [7:0] h, input int n);
    put(1, 0, h);
    for (int i = 0; i < n; i++) put(0, i == n - 1, 8'($urandom));
  endtask

  task automatic pkt_long(input logic [7:0] h);
    put(1, 0, h);
    for (int i = 0; i < BEATS + 2; i++) put(0, i == BEATS + 1, 8'($urandom));
  endtask

  task automatic pkt_badhdr();
    put(1, 0, 8'h07); put(0, 0, 8'($urandom)); put(0, 1, 8'($urandom));
  endtask

  // Packet-level parse: the current packet lives in a byte queue.
  task automatic model_rx(input bit s, input bit e, input logic [7:0] d, output bit bad);
    logic [SZ-1:0] v;
    bad = 0;
    if (mdisc) begin
      if (e) mdisc = 0;
      return;
    end
    if (cur.size() != 0 && s) begin
      bad = 1;
      cur.delete();
    end
    if (cur.size() == 0) begin
      if (!s) begin
        bad = 1;
        return;
      end
      if (d == 8'h01 || d == 8'h02) cur.push_back(d);
      else begin
        bad = 1;
        mdisc = !e;
      end
      return;
    end
    cur.push_back(d);
    if (e) begin
      if (cur.size() == BEATS + 1) begin
        v = '0;
        for (int i = 1; i <= BEATS; i++) v = (v << 8) | SZ'(cur[i]);
        if (cur[0] == 8'h01) begin ma = v; mpa = 1; end
        else begin mb = v; mpb = 1; end
      end else bad = 1;
      cur.delete();
    end else if (cur.size() == BEATS + 1) begin
      bad = 1;
      mdisc = 1;
      cur.delete();
    end
  endtask

  task automatic model_edge();
    bit pre_ready, tx_idle, bad;
    logic [2*SZ-1:0] p;
    pre_ready = !(mpa && mpb);
    tx_idle   = (txq.size() == 0);
    bad       = 0;
    if (!tx_idle && ready_in) void'(txq.pop_front());
    if (mpa && mpb && tx_idle) begin
      p = {{SZ{1'b0}}, ma} * {{SZ{1'b0}}, mb};
      for (int i = OB - 1; i >= 0; i--) txq.push_back(p[i*8 +: 8]);
      mpa = 0; mpb = 0;
    end
    if (valid_in && pre_ready) begin
      model_rx(startofpacket_in, endofpacket_in, data_in, bad);
      void'(inq.pop_front());
    end
    if (bad && mcnt < 255) mcnt++;
    merr = bad;
  endtask

  task automatic check_outputs();
    int n;
    n = txq.size();
    check("ready_out", ready_out, !(mpa && mpb));
    check("valid_out", valid_out, n != 0);
    check("data_out", data_out, (n != 0) ? txq[0] : 8'h00);
    check("sop_out", startofpacket_out, n == OB);
    check("eop_out", endofpacket_out, n == 1);
`ifdef AVST_MULT_ERR_EN
    check("err_out", err_out, merr);
    check("err_cnt", err_cnt, mcnt);
`endif
  endtask

  task automatic drive_inputs();
    case (rmode)
      0:       ready_in = 1'b1;
      1:       begin ready_in = ph; ph = !ph; end
      default: ready_in = ($urandom % 4) != 0;
    endcase
    if (inq.size() != 0 && ($urandom % 100) < vpct) begin
      valid_in         = 1'b1;
      startofpacket_in = inq[0].sop;
      endofpacket_in   = inq[0].eop;
      data_in          = inq[0].d;
    end else begin
      valid_in         = 1'b0;
      startofpacket_in = 1'($urandom);
      endofpacket_in   = 1'($urandom);
      data_in          = 8'($urandom);
    end
  endtask

  task automatic step();
    check_outputs();
    drive_inputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run_drain(input int budget);
    int k;
    k = 0;
    while ((inq.size() != 0 || txq.size() != 0 || (mpa && mpb)) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) check("drain_budget", inq.size() + txq.size(), 0);
  endtask

  initial begin
    int k;
    _rst = 1'b0; valid_in = 1'b0; startofpacket_in = 1'b0; endofpacket_in = 1'b0;
    data_in = 8'h00; ready_in = 1'b0;
    model_reset();
    rmode = 0; vpct = 100; ph = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs();
    _rst = 1'b1;

    pkt_good(8'h01, SZ'(3)); pkt_good(8'h02, SZ'(5));
    run_drain(200);

    rmode = 1;
    pkt_good(8'h01, '1); pkt_good(8'h02, '1);
    run_drain(200);

    rmode = 0;
    pkt_short(8'h01, 3); pkt_good(8'h01, SZ'(32'h0000_1234)); pkt_good(8'h02, SZ'(32'h10));
    run_drain(200);

    pkt_badhdr(); pkt_good(8'h01, SZ'(2)); pkt_good(8'h02, SZ'(7));
    run_drain(200);

    // Reset while the product is mid-stream.
    pkt_good(8'h01, SZ'($urandom)); pkt_good(8'h02, SZ'($urandom));
    k = 0;
    while (txq.size() != OB - 3 && k < 200) begin step(); k++; end
    check("rst_at_beat3", txq.size(), OB - 3);
    _rst = 1'b0; valid_in = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    _rst = 1'b1;
    repeat (20) step();
    pkt_good(8'h01, SZ'($urandom)); pkt_good(8'h02, SZ'($urandom));
    run_drain(200);

    for (int i = 0; i < 150; i++) begin
      rmode = $urandom_range(0, 2);
      vpct  = $urandom_range(50, 100);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: pkt_good(($urandom % 2) ? 8'h01 : 8'h02, SZ'($urandom));
        4:          pkt_short(($urandom % 2) ? 8'h01 : 8'h02, $urandom_range(1, BEATS - 1));
        5:          pkt_long(($urandom % 2) ? 8'h01 : 8'h02);
        6:          pkt_badhdr();
        7:          put(0, 1'($urandom), 8'($urandom));
        default: begin
          put(1, 0, 8'h01); put(0, 0, 8'($urandom)); put(0, 0, 8'($urandom));
          pkt_good(8'h02, SZ'($urandom));
        end
      endcase
      if (i % 10 == 9) run_drain(2000);
    end
    run_drain(5000);
    repeat (5) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
